// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ALU control enum, ALUOp codes and R-type funct constants
package pipeline_pkg;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_PASS0
  } alu_ctrl_t;
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
endpackage

// File: rtl/alu_control.sv
// alu_control: maps ALUOp (alu_op) and funct to the ALU operation (ctrl); purely combinational
module alu_control
  import pipeline_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_t  ctrl
);
  // Only the R-type code consults funct; unknown functs produce a zero result.
  always_comb begin
    ctrl = alu_op == ALUOP_MEM   ? ALU_ADD :
           alu_op == ALUOP_BEQ   ? ALU_SUB :
           alu_op != ALUOP_RTYPE ? ALU_ADD :
           funct == FUNCT_ADD    ? ALU_ADD :
           funct == FUNCT_SUB    ? ALU_SUB :
           funct == FUNCT_AND    ? ALU_AND :
           funct == FUNCT_OR     ? ALU_OR  :
           funct == FUNCT_SLT    ? ALU_SLT : ALU_PASS0;
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage (operand mux, ALU, branch adder, dest mux) feeding the EX/MEM register.
// Ports: clk, reset (sync, active-low), stall (hold), flush (bubble), ID/EX control and data in;
// registered MEM/WB control, branch_target, zero, alu_result, write_data, write_reg out.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              RegDstIn,
  input  logic              ALUSrcIn,
  input  logic              MemtoRegIn,
  input  logic              RegWriteIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              BranchIn,
  input  logic              ALUOp1In,
  input  logic              ALUOp0In,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [REG_W-1:0]  instr_2016,
  input  logic [REG_W-1:0]  instr_1511,
  output logic              MemtoRegOut,
  output logic              RegWriteOut,
  output logic              MemReadOut,
  output logic              MemWriteOut,
  output logic              BranchOut,
  output logic [DATA_W-1:0] branch_target,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] write_data,
  output logic [REG_W-1:0]  write_reg
);
  alu_ctrl_t         ctrl;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_y;
  logic              slt;
  alu_control u_alu_control (
    .alu_op({ALUOp1In, ALUOp0In}),
    .funct (s_extend[5:0]),
    .ctrl  (ctrl)
  );
  always_comb begin
    op_b  = ALUSrcIn ? s_extend : rdata2;
    slt   = $signed(rdata1) < $signed(op_b);
    alu_y = ctrl == ALU_ADD ? rdata1 + op_b :
            ctrl == ALU_SUB ? rdata1 - op_b :
            ctrl == ALU_AND ? rdata1 & op_b :
            ctrl == ALU_OR  ? rdata1 | op_b :
            ctrl == ALU_SLT ? {{(DATA_W-1){1'b0}}, slt} : '0;
  end
  // Reset and flush both load a bubble; flush wins over stall.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      MemtoRegOut   <= 1'b0;
      RegWriteOut   <= 1'b0;
      MemReadOut    <= 1'b0;
      MemWriteOut   <= 1'b0;
      BranchOut     <= 1'b0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      write_data    <= '0;
      write_reg     <= '0;
    end else if (!stall) begin
      MemtoRegOut   <= MemtoRegIn;
      RegWriteOut   <= RegWriteIn;
      MemReadOut    <= MemReadIn;
      MemWriteOut   <= MemWriteIn;
      BranchOut     <= BranchIn;
      branch_target <= npc + (s_extend << 2);
      zero          <= alu_y == '0;
      alu_result    <= alu_y;
      write_data    <= rdata2;
      write_reg     <= RegDstIn ? instr_1511 : instr_2016;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized and directed check of execute_stage against a behavioural model
module tb_execute_stage;
  logic clk = 1'b0;
  logic reset, stall, flush;
  logic RegDstIn, ALUSrcIn, MemtoRegIn, RegWriteIn, MemReadIn, MemWriteIn, BranchIn;
  logic ALUOp1In, ALUOp0In;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [4:0] instr_2016, instr_1511;
  logic MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut, zero;
  logic [31:0] branch_target, alu_result, write_data;
  logic [4:0] write_reg;
  logic [106:0] act, exp_v;
  logic run = 1'b0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  execute_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .RegDstIn(RegDstIn), .ALUSrcIn(ALUSrcIn), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .BranchIn(BranchIn),
    .ALUOp1In(ALUOp1In), .ALUOp0In(ALUOp0In),
    .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .instr_2016(instr_2016), .instr_1511(instr_1511),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
    .MemWriteOut(MemWriteOut), .BranchOut(BranchOut), .branch_target(branch_target),
    .zero(zero), .alu_result(alu_result), .write_data(write_data), .write_reg(write_reg)
  );
  assign act = {MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut,
                branch_target, zero, alu_result, write_data, write_reg};
  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] f;
    f = s_extend[5:0];
    if (op != 2'b10) return op == 2'b01 ? a - b : a + b;
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [106:0] model_next();
    logic [31:0] r;
    r = alu_ref({ALUOp1In, ALUOp0In}, rdata1, ALUSrcIn ? s_extend : rdata2);
    return {MemtoRegIn, RegWriteIn, MemReadIn, MemWriteIn, BranchIn,
            npc + s_extend * 32'd4, r == 32'd0, r, rdata2, RegDstIn ? instr_1511 : instr_2016};
  endfunction
  always @(posedge clk)
    exp_v <= (!reset || flush) ? '0 : stall ? exp_v : model_next();
  task automatic chk(input string name, input logic [106:0] got, input logic [106:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  always @(negedge clk) if (run) chk("model", act, exp_v);
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rnd_data();
    logic [5:0] fl [5];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    {RegDstIn, ALUSrcIn, MemtoRegIn, RegWriteIn, MemReadIn, MemWriteIn, BranchIn} = 7'($urandom);
    {ALUOp1In, ALUOp0In} = 2'($urandom);
    npc = $urandom;
    rdata1 = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
    rdata2 = $urandom_range(0, 3) == 0 ? rdata1 : $urandom;
    s_extend = $urandom;
    if ($urandom_range(0, 3) != 0) s_extend[5:0] = fl[$urandom_range(0, 4)];
    instr_2016 = 5'($urandom);
    instr_1511 = 5'($urandom);
  endtask
  task automatic rtype(input logic [31:0] a, input logic [5:0] f);
    rnd_data();
    {ALUOp1In, ALUOp0In} = 2'b10;
    rdata1 = a;
    rdata2 = 32'd5;
    ALUSrcIn = 1'b0;
    RegDstIn = 1'b1;
    instr_1511 = 5'd9;
    s_extend = {26'd0, f};
  endtask
  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    rnd_data();
    run = 1'b1;
    tick();
    rnd_data();
    tick();
    chk("reset_all", act, '0);
    chk("reset_zero", {106'd0, zero}, '0);
    reset = 1'b1;
    rtype(32'd7, 6'b100010);
    tick();
    chk("sub_result", {75'd0, alu_result}, 107'd2);
    chk("sub_wreg", {102'd0, write_reg}, 107'd9);
    rtype(32'd7, 6'b101010);
    tick();
    chk("slt_false", {75'd0, alu_result}, 107'd0);
    rtype(32'hFFFF_FFFF, 6'b101010);
    tick();
    chk("slt_neg", {75'd0, alu_result}, 107'd1);
    rtype(32'd7, 6'b000000);
    tick();
    chk("pass0", {74'd0, zero, alu_result}, {74'd0, 1'b1, 32'd0});
    rnd_data();
    {ALUOp1In, ALUOp0In} = 2'b01; ALUSrcIn = 1'b0;
    rdata1 = 32'h1234; rdata2 = 32'h1234; npc = 32'h100; s_extend = 32'hFFFF_FFFE; BranchIn = 1'b1;
    tick();
    chk("beq", {73'd0, BranchOut, zero, branch_target}, {73'd0, 1'b1, 1'b1, 32'hF8});
    rnd_data();
    {ALUOp1In, ALUOp0In} = 2'b00; ALUSrcIn = 1'b1; rdata1 = 32'h1000; s_extend = 32'h10;
    RegDstIn = 1'b0; instr_2016 = 5'd3; {MemReadIn, MemtoRegIn, RegWriteIn} = 3'b111;
    tick();
    chk("lw", {67'd0, MemReadOut, MemtoRegOut, RegWriteOut, alu_result, write_reg},
        {67'd0, 3'b111, 32'h1010, 5'd3});
    rtype(32'd7, 6'b100000);
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      rnd_data();
      tick();
      chk("stall_hold", {75'd0, alu_result}, 107'd12);
    end
    flush = 1'b1;
    tick();
    chk("stall_flush", act, '0);
    stall = 1'b0; flush = 1'b0;
    rnd_data();
    {ALUOp1In, ALUOp0In} = 2'b00; ALUSrcIn = 1'b1; rdata1 = 32'hFFFF_FFFF; s_extend = 32'd1;
    npc = 32'hFFFF_FFFC;
    tick();
    chk("wrap", {42'd0, branch_target, zero, alu_result}, {42'd0, 32'd0, 1'b1, 32'd0});
    reset = 1'b0; stall = 1'b1;
    rnd_data();
    tick();
    chk("reset_over_stall", act, '0);
    reset = 1'b1;
    tick();
    chk("stall_after_reset", act, '0);
    stall = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      reset = $urandom_range(0, 19) != 0;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 4) == 0;
      rnd_data();
      tick();
    end
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 5-stage MIPS pipeline, with the EX/MEM pipeline register built in. It consumes the registered outputs of the decode-to-execute pipe register and derives the ALU operation from ALUOp and the funct field. It computes the ALU result, zero flag, branch target and destination register, then registers them with the MEM/WB control bits for the memory stage. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- DATA_W, 32, datapath width (npc, operands, result, branch target)
- REG_W, 5, register-specifier width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low (0 = reset)
- stall  input  1  hold EX/MEM contents
- flush  input  1  load a bubble into EX/MEM
- RegDstIn, ALUSrcIn, MemtoRegIn, RegWriteIn, MemReadIn, MemWriteIn, BranchIn  input  1 each  control bits from ID/EX
- ALUOp1In, ALUOp0In  input  1 each  ALUOp[1:0]
- npc, rdata1, rdata2, s_extend  input  DATA_W each  next PC, rs value, rt value, sign-extended immediate
- instr_2016, instr_1511  input  REG_W each  rt and rd specifiers
- MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut  output  1 each  registered control
- branch_target  output  DATA_W  registered npc + (s_extend << 2)
- zero  output  1  registered (alu_result == 0)
- alu_result  output  DATA_W  registered ALU result
- write_data  output  DATA_W  registered rdata2 (store data)
- write_reg  output  REG_W  registered destination register

## Operation
- Operand B is s_extend when ALUSrcIn = 1, otherwise rdata2. Operand A is always rdata1.
- ALU control maps {ALUOp1In, ALUOp0In} and funct = s_extend[5:0] as follows:
  - 00 -> ADD
  - 01 -> SUB
  - 11 -> ADD
  - 10 with funct 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT
  - 10 with any other funct -> PASS0 (result 0)
- ADD and SUB are modulo 2^DATA_W; overflow is ignored and raises no trap.
- SLT is a signed compare; the result is 1 or 0, zero-extended.
- zero is computed from the 32-bit result after the operation.
- branch_target = npc + {s_extend[DATA_W-3:0], 2'b00}, modulo 2^DATA_W; wrap-around is allowed.
- write_reg is instr_1511 when RegDstIn = 1, otherwise instr_2016.
- RegDstIn and ALUSrcIn are consumed in this stage and are not forwarded.
- EX/MEM update priority at each rising clk:
  - reset = 0: all outputs go to 0.
  - otherwise flush = 1: all outputs go to 0 (bubble). flush overrides stall.
  - otherwise stall = 1: all outputs hold their value.
  - otherwise: all outputs load the newly computed values.

## Timing
- Latency is 1 cycle: inputs presented in cycle N appear on the outputs after the rising edge that ends cycle N.
- Every output resets to 0, including zero = 0 (the register holds a bubble, not a computed zero).
- Reset asserted mid-stream clears the register at the next edge, regardless of stall or flush. When reset is released, the first load happens at the first edge with reset = 1 and stall = 0.
- A flush and a stall in the same cycle produce a bubble; the held instruction is discarded.
- A stall held for K cycles keeps the outputs constant for K edges. Input changes during the stall are ignored.
- The ALU and ALU control are purely combinational between the inputs and the register; there is no combinational path from any input to any output.

## Structure
- Shared package pipeline_pkg holds:
  - the ALU control enum (ADD, SUB, AND, OR, SLT, PASS0)
  - ALUOp codes (ALUOP_MEM = 2'b00, ALUOP_BEQ = 2'b01, ALUOP_RTYPE = 2'b10)
  - funct constants (FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT)
- Sub-module alu_control is combinational: ALUOp plus funct in, ALU enum out. The ALU, muxes and EX/MEM register are written inline in execute_stage.

## Test plan
- Reset: hold reset = 0 for 2 cycles with random inputs -> all outputs 0 and zero = 0. Release reset; the next edge loads the inputs.
- R-type: ALUOp = 10, rdata1 = 7, rdata2 = 5, ALUSrc = 0, RegDst = 1, rd = 9.
  - funct 100010 -> alu_result = 2, write_reg = 9.
  - funct 101010 -> alu_result = 0.
  - rdata1 = 0xFFFFFFFF (-1) with funct 101010 -> alu_result = 1.
  - funct 000000 -> alu_result = 0, zero = 1.
- beq: ALUOp = 01, rdata1 = rdata2 = 0x1234, npc = 0x100, s_extend = 0xFFFFFFFE, Branch = 1 -> zero = 1, branch_target = 0xF8, BranchOut = 1.
- lw: ALUOp = 00, ALUSrc = 1, rdata1 = 0x1000, s_extend = 0x10, RegDst = 0, rt = 3, MemRead = MemtoReg = RegWrite = 1 -> alu_result = 0x1010, write_reg = 3, all three control outputs 1.
- Stall/flush: load an instruction, then assert stall for 3 cycles with new inputs -> outputs unchanged. Then assert stall and flush together -> all outputs 0. Deassert both -> the next edge loads the current inputs.
- Wrap: npc = 0xFFFFFFFC, s_extend = 1 -> branch_target = 0x00000000. ADD of 0xFFFFFFFF + 1 -> alu_result = 0, zero = 1.
